// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one-word reads, and holds
// the fetched word for decode. Backend redirects may orphan a read in flight.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_rdata,
  output logic [31:0] fetch_pc_curr,
  output logic [31:0] fetch_pc_next
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_discard;
  logic        w_discard_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [31:0] r_pc_curr;
  logic [31:0] w_pc_curr_nxt;
  logic [31:0] r_pc_next;
  logic [31:0] w_pc_next_nxt;
  logic [3:0]  w_rmask;
  logic [31:0] w_pc_inc;
  logic [31:0] w_redir_pc;

  assign w_pc_inc   = r_pc + 32'd4;
  assign w_redir_pc = redirect_pc & ALIGN_MASK;

  // Next-state and request logic; a redirect pre-empts every state action.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_discard_nxt = r_discard;
    w_valid_nxt   = r_valid;
    w_instr_nxt   = r_instr;
    w_pc_curr_nxt = r_pc_curr;
    w_pc_next_nxt = r_pc_next;
    w_rmask       = 4'h0;
    if (redirect_valid) begin
      w_pc_nxt    = w_redir_pc;
      w_valid_nxt = 1'b0;
      if (r_state == S_WAIT && !imem_resp) begin
        // The outstanding read still has to come back; remember to drop it.
        w_discard_nxt = 1'b1;
      end else begin
        w_discard_nxt = 1'b0;
        w_state_nxt   = S_REQ;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          w_rmask     = 4'hF;
          w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp) begin
            if (r_discard) begin
              w_discard_nxt = 1'b0;
              w_state_nxt   = S_REQ;
            end else begin
              w_instr_nxt   = imem_rdata;
              w_pc_curr_nxt = r_pc;
              w_pc_next_nxt = w_pc_inc;
              w_valid_nxt   = 1'b1;
              w_pc_nxt      = w_pc_inc;
              w_state_nxt   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Accepting the held word launches the next read in the same cycle.
          if (r_valid && !stall_inst) begin
            w_rmask     = 4'hF;
            w_valid_nxt = 1'b0;
            w_state_nxt = S_WAIT;
          end
        end
        default: begin
          w_state_nxt = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_discard <= 1'b0;
      r_valid   <= 1'b0;
      r_instr   <= 32'h0;
      r_pc_curr <= RESET_PC;
      r_pc_next <= RESET_PC + 32'd4;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_discard <= w_discard_nxt;
      r_valid   <= w_valid_nxt;
      r_instr   <= w_instr_nxt;
      r_pc_curr <= w_pc_curr_nxt;
      r_pc_next <= w_pc_next_nxt;
    end
  end

  assign imem_addr     = r_pc & ALIGN_MASK;
  assign imem_rmask    = rst ? 4'h0 : w_rmask;
  assign instr_valid   = r_valid;
  assign instr_rdata   = r_instr;
  assign fetch_pc_curr = r_pc_curr;
  assign fetch_pc_next = r_pc_next;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a transaction-level fetch model plus a reactive memory,
// directed scenarios pinned with literal values, then a randomized soak.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        stall_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic [31:0] fetch_pc_curr;
  logic [31:0] fetch_pc_next;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .stall_inst     (stall_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_rdata    (instr_rdata),
    .fetch_pc_curr  (fetch_pc_curr),
    .fetch_pc_next  (fetch_pc_next)
  );

  int total = 0;
  int bad   = 0;

  // Model: next fetch address, whether a read must be launched, whether one is
  // in flight (and doomed), and the word currently offered to decode.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_curr;
  bit          m_issue;
  bit          m_busy;
  bit          m_drop;
  bit          m_valid;
  bit          m_known = 1'b0;

  // Memory: one outstanding read with a countdown to its response.
  int          mem_cnt   = 0;
  int          lat_next  = 1;
  logic [31:0] mem_addr  = 32'h0;
  bit          mem_fixed = 1'b1;
  logic [31:0] mem_val   = 32'h0;
  bit          spur_en   = 1'b0;

  logic [3:0]  obs_rmask;
  logic [31:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_rdata;
  logic [31:0] obs_curr;
  logic [31:0] obs_next;

  function automatic logic [31:0] hashw(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_fire(input bit r, input bit rd, input bit st);
    return !r && !rd && (m_issue || (m_valid && !st));
  endfunction

  task automatic compare();
    bit fire;
    fire = model_fire(rst, redirect_valid, stall_inst);
    chk("rmask", {28'h0, imem_rmask}, fire ? 32'hF : 32'h0);
    chk("addr", imem_addr, m_pc);
    chk("valid", {31'h0, instr_valid}, {31'h0, m_valid});
    if (m_valid) begin
      chk("rdata", instr_rdata, m_instr);
      chk("pc_curr", fetch_pc_curr, m_curr);
      chk("pc_next", fetch_pc_next, m_curr + 32'd4);
    end
  endtask

  task automatic step();
    bit          s_rst, s_redir, s_stall, s_resp, s_fire, s_req;
    logic [31:0] s_rpc, s_rdata, s_addr;
    if (mem_cnt == 1) begin
      imem_resp  = 1'b1;
      imem_rdata = mem_fixed ? mem_val : hashw(mem_addr);
    end else if (spur_en && mem_cnt == 0 && $urandom_range(19) == 0) begin
      imem_resp  = 1'b1;
      imem_rdata = $urandom;
    end else begin
      imem_resp  = 1'b0;
      imem_rdata = $urandom;
    end
    #1;
    obs_rmask = imem_rmask;
    obs_addr  = imem_addr;
    obs_valid = instr_valid;
    obs_rdata = instr_rdata;
    obs_curr  = fetch_pc_curr;
    obs_next  = fetch_pc_next;
    if (m_known) compare();
    s_rst   = rst;
    s_redir = redirect_valid;
    s_stall = stall_inst;
    s_resp  = imem_resp;
    s_rpc   = redirect_pc;
    s_rdata = imem_rdata;
    s_addr  = imem_addr;
    s_req   = (imem_rmask == 4'hF);
    s_fire  = model_fire(s_rst, s_redir, s_stall);
    @(posedge clk);
    if (s_rst) begin
      m_pc = RST_PC; m_issue = 1'b1; m_busy = 1'b0; m_drop = 1'b0;
      m_valid = 1'b0; m_instr = 32'h0; m_curr = RST_PC; m_known = 1'b1;
    end else if (s_redir) begin
      m_pc    = s_rpc & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      if (m_busy && !s_resp) m_drop = 1'b1;
      else begin m_busy = 1'b0; m_drop = 1'b0; m_issue = 1'b1; end
    end else if (s_fire) begin
      m_issue = 1'b0; m_busy = 1'b1; m_valid = 1'b0;
    end else if (m_busy && s_resp) begin
      m_busy = 1'b0;
      if (m_drop) begin
        m_drop = 1'b0; m_issue = 1'b1;
      end else begin
        m_valid = 1'b1; m_instr = s_rdata; m_curr = m_pc; m_pc = m_pc + 32'd4;
      end
    end
    if (s_rst) mem_cnt = 0;
    else begin
      if (s_resp && mem_cnt == 1) mem_cnt = 0;
      else if (mem_cnt > 1) mem_cnt--;
      if (s_req) begin mem_cnt = lat_next; mem_addr = s_addr; end
    end
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; stall_inst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_resp = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);

    // Reset state
    step();
    step();
    chk("rst_rmask", {28'h0, obs_rmask}, 32'h0);
    chk("rst_valid", {31'h0, obs_valid}, 32'h0);
    chk("rst_rdata", obs_rdata, 32'h0);
    chk("rst_curr", obs_curr, RST_PC);
    chk("rst_next", obs_next, RST_PC + 32'd4);

    // 1-cycle memory, no stall
    rst = 1'b0; lat_next = 1; mem_val = 32'h00000013;
    step();
    chk("t1_rmask", {28'h0, obs_rmask}, 32'hF);
    chk("t1_addr", obs_addr, 32'h1eceb000);
    step();
    chk("t1_wait_valid", {31'h0, obs_valid}, 32'h0);
    step();
    chk("t1_valid", {31'h0, obs_valid}, 32'h1);
    chk("t1_rdata", obs_rdata, 32'h00000013);
    chk("t1_curr", obs_curr, 32'h1eceb000);
    chk("t1_next", obs_next, 32'h1eceb004);
    chk("t1_addr2", obs_addr, 32'h1eceb004);
    chk("t1_rmask2", {28'h0, obs_rmask}, 32'hF);

    // Stall holds the instruction
    mem_val = 32'hDEADBEEF; stall_inst = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_valid", {31'h0, obs_valid}, 32'h1);
      chk("t2_rdata", obs_rdata, 32'hDEADBEEF);
      chk("t2_curr", obs_curr, 32'h1eceb004);
      chk("t2_rmask", {28'h0, obs_rmask}, 32'h0);
    end
    stall_inst = 1'b0; lat_next = 3;
    step();
    chk("t2_rel_rmask", {28'h0, obs_rmask}, 32'hF);
    chk("t2_rel_addr", obs_addr, 32'h1eceb008);

    // Redirect while waiting on a 3-cycle memory
    redirect_valid = 1'b1; redirect_pc = 32'h00001002;
    step();
    chk("t3_redir_rmask", {28'h0, obs_rmask}, 32'h0);
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t3_drop_valid", {31'h0, obs_valid}, 32'h0);
    end
    step();
    chk("t3_rmask", {28'h0, obs_rmask}, 32'hF);
    chk("t3_addr", obs_addr, 32'h00001000);
    mem_val = 32'hCAFE0001; lat_next = 2;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = obs_valid;
    end
    chk("t3_seen", {31'h0, seen}, 32'h1);
    chk("t3_curr", obs_curr, 32'h00001000);
    chk("t3_rdata", obs_rdata, 32'hCAFE0001);

    // Redirect coincident with the response
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h00002000;
    step();
    chk("t4_valid", {31'h0, obs_valid}, 32'h0);
    redirect_valid = 1'b0; mem_val = 32'h12345678; lat_next = 2;
    step();
    chk("t4_rmask", {28'h0, obs_rmask}, 32'hF);
    chk("t4_addr", obs_addr, 32'h00002000);
    step();
    step();
    stall_inst = 1'b1;
    step();
    chk("t4_pvalid", {31'h0, obs_valid}, 32'h1);
    chk("t4_curr", obs_curr, 32'h00002000);
    chk("t4_rdata", obs_rdata, 32'h12345678);

    // Redirect to the top word squashes the held instruction
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    step();
    redirect_valid = 1'b0; stall_inst = 1'b0; lat_next = 1; mem_val = 32'h600DF00D;
    step();
    chk("t5_squash", {31'h0, obs_valid}, 32'h0);
    chk("t5_addr", obs_addr, 32'hFFFFFFFC);
    step();
    step();
    chk("t5_curr", obs_curr, 32'hFFFFFFFC);
    chk("t5_next", obs_next, 32'h00000000);
    chk("t5_wrap_addr", obs_addr, 32'h00000000);

    // Reset in HOLD, then in WAIT with a coincident response
    stall_inst = 1'b1;
    step();
    step();
    chk("t6_hold_valid", {31'h0, obs_valid}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0; stall_inst = 1'b0; lat_next = 1; mem_val = 32'hBAD0BAD0;
    step();
    chk("t6a_valid", {31'h0, obs_valid}, 32'h0);
    chk("t6a_addr", obs_addr, RST_PC);
    chk("t6a_rmask", {28'h0, obs_rmask}, 32'hF);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_val = 32'h00000077;
    step();
    chk("t6b_valid", {31'h0, obs_valid}, 32'h0);
    chk("t6b_addr", obs_addr, RST_PC);
    step();
    step();
    chk("t6b_curr", obs_curr, RST_PC);
    chk("t6b_rdata", obs_rdata, 32'h00000077);

    // Randomized soak
    mem_fixed = 1'b0; spur_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(150) == 0);
      redirect_valid = ($urandom_range(11) == 0);
      redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(15)))
                                                 : $urandom;
      stall_inst     = ($urandom_range(2) == 0);
      lat_next       = $urandom_range(5, 1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage. Owns the architectural fetch PC and issues one-word reads on the instruction memory port.
- Presents the fetched word, plus its pc_curr/pc_next pair, to the decode stage, which consumes them as imem_rdata and fetch_output.
- Holds the instruction while decode stalls.
- Handles backend redirects (branch/jump resolution, flush), including discarding a response already in flight.

Parameters:
- RESET_PC, 32'h1eceb000, PC of the first fetch after reset.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- imem_addr  output  32  read address; word-aligned
- imem_rmask  output  4  4'hF for exactly one cycle per request, else 4'h0
- imem_rdata  input  32  read data; valid only when imem_resp=1
- imem_resp  input  1  one-cycle response pulse; at most one per request
- stall_inst  input  1  decode cannot accept this cycle
- redirect_valid  input  1  backend redirect request
- redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 0
- instr_valid  output  1  instr_rdata/fetch_pc_* hold a live instruction
- instr_rdata  output  32  fetched instruction to decode
- fetch_pc_curr  output  32  PC of instr_rdata
- fetch_pc_next  output  32  fetch_pc_curr + 4, modulo 2^32

Behaviour:
- Clock/reset: single clock domain. Reset is synchronous and active-high; all state updates on the posedge of clk.
- Internal state:
  - pc register.
  - FSM state in {REQ, WAIT, HOLD}.
  - discard flag.
  - Output registers for instr_rdata, fetch_pc_curr and fetch_pc_next.
- Reset values:
  - pc = RESET_PC; state = REQ; discard = 0.
  - instr_valid = 0; instr_rdata = 0.
  - fetch_pc_curr = RESET_PC; fetch_pc_next = RESET_PC + 4.
  - imem_rmask = 0 during the reset cycle.
  - rst mid-operation overrides everything, including a coincident imem_resp, which is dropped.
- imem_addr = pc at all times, with bits [1:0] = 00. imem_rmask is combinational.
- REQ:
  - Drive imem_rmask = 4'hF for one cycle, then go to WAIT.
  - An imem_resp seen in REQ is ignored.
- WAIT:
  - On imem_resp with discard = 1: clear discard, go to REQ. Nothing is presented.
  - On imem_resp with discard = 0:
    - instr_rdata <= imem_rdata; fetch_pc_curr <= pc; fetch_pc_next <= pc + 4.
    - instr_valid <= 1; pc <= pc + 4; go to HOLD.
  - Latency: the instruction is visible on the cycle after the response.
- HOLD:
  - Outputs are frozen while stall_inst = 1.
  - The instruction is accepted on any cycle where instr_valid = 1 and stall_inst = 0. In that same cycle:
    - Assert imem_rmask = 4'hF with imem_addr = pc (overlapped prefetch).
    - instr_valid <= 0; go to WAIT.
  - An imem_resp seen in HOLD is ignored.
  - Steady-state throughput with 1-cycle memory: one instruction every 2 cycles.
- Redirect (redirect_valid = 1) has priority over everything except rst:
  - pc <= {redirect_pc[31:2], 2'b00}; instr_valid <= 0.
  - imem_rmask = 0 in the redirect cycle.
  - In WAIT with no imem_resp this cycle: discard <= 1, stay in WAIT.
  - In WAIT with imem_resp this cycle: drop the response, discard stays 0, go to REQ.
  - In REQ or HOLD: go to REQ. A held instruction is squashed even if stall_inst = 0.
  - Back-to-back redirects: the last one wins. discard never exceeds one outstanding request.
- Arithmetic: all PC arithmetic is 32-bit and wraps. pc = 32'hFFFFFFFC yields pc_next = 32'h00000000.
- imem_rdata is sampled only in the imem_resp cycle. Memory latency is unbounded; WAIT persists indefinitely.

Test Plan:
- Reset, then 1-cycle memory returning 32'h00000013, stall_inst = 0:
  - First imem_rmask = 4'hF with imem_addr = 32'h1eceb000 on the first cycle after rst deasserts.
  - instr_valid = 1 with fetch_pc_curr = 32'h1eceb000, fetch_pc_next = 32'h1eceb004.
  - Subsequent addresses increment by 4.
- Response 32'hDEADBEEF, then stall_inst = 1 for 5 cycles:
  - Outputs stay constant and instr_valid stays 1.
  - No new imem_rmask during the stall.
  - Request to pc + 4 fires on the cycle stall_inst drops.
- Redirect to 32'h00001002 while WAIT with a 3-cycle memory:
  - The late response is dropped and instr_valid stays 0.
  - Next request address is 32'h00001000; its data is presented with fetch_pc_curr = 32'h00001000.
- Redirect to 32'h00002000 in the same cycle as imem_resp:
  - The response is discarded.
  - Next request at 32'h00002000 with no extra discard; the following response is presented.
- Redirect to 32'hFFFFFFFC:
  - Fetched instruction shows fetch_pc_next = 32'h00000000.
  - Next imem_addr = 32'h00000000.
- rst asserted in HOLD and in WAIT (coincident with imem_resp):
  - instr_valid = 0 and pc = RESET_PC on the following cycle.
  - The coincident response is not presented; a fresh request is made to RESET_PC.
